// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, oversampling constants and majority vote for uart_rx_os16 (macro UART_RX_PARITY_EN)
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    // Tick indices within a bit at which the line is sampled for the vote
    localparam logic [3:0] SMP_A    = 4'd7;
    localparam logic [3:0] SMP_B    = 4'd8;
    localparam logic [3:0] SMP_C    = 4'd9;
    localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - 16x oversampling tick generator with synchronous restart
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap   = (cnt_q == CW'(DIV - 1));
    assign tick_o = wrap & ~restart_i;

    // Divider next value: held at zero while restarting, wraps after DIV clocks
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || wrap) begin
            cnt_d = '0;
        end
    end

    // Divider register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampled UART receiver, 8N1 or 8E1 with macro UART_RX_PARITY_EN
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    rx_state_e  state_q, state_d;
    logic       sync1_q, sync2_q;
    logic       rx_last_q;
    logic [3:0] s_cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic [7:0] data_q;
    logic       smp_a_q, smp_b_q;
    logic       valid_q, ferr_q, perr_q;
    logic       valid_d, ferr_d, perr_d;
    logic       rx_s, tick, at_mid, at_end, maj, fall;
`ifdef UART_RX_PARITY_EN
    logic       par_q;
`endif

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (state_q == ST_IDLE),
        .tick_o    (tick)
    );

    assign rx_s   = sync2_q;
    assign at_mid = tick && (s_cnt_q == SMP_C);
    assign at_end = tick && (s_cnt_q == SMP_LAST);
    assign maj    = maj3(smp_a_q, smp_b_q, rx_s);
    // rx_last_q is forced high outside IDLE, so a line that fell while the
    // previous frame was finishing still looks like a fresh edge in IDLE.
    assign fall   = rx_last_q & ~rx_s;

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_frame_err  = ferr_q;
    assign o_parity_err = perr_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: bit boundaries on tick 15, decisions on the tick-9 vote
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (fall) state_d = ST_START;
            ST_START: begin
                if (at_mid && maj) state_d = ST_IDLE;
                else if (at_end)   state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at_end && (bit_idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (at_end) state_d = ST_STOP;
`endif
            ST_STOP:   if (at_mid) state_d = maj ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rx_s) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: busy level and the end-of-frame strobes
    always_comb begin
        o_busy  = (state_q != ST_IDLE);
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        if (state_q == ST_STOP && at_mid) begin
            valid_d = maj;
            ferr_d  = ~maj;
`ifdef UART_RX_PARITY_EN
            perr_d  = maj & (^{shift_q, par_q});
`endif
        end
    end

    // Synchronizer, sample counters, shift register and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_last_q <= 1'b1;
            s_cnt_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            smp_a_q   <= 1'b1;
            smp_b_q   <= 1'b1;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            sync1_q   <= i_rx;
            sync2_q   <= sync1_q;
            rx_last_q <= (state_q == ST_IDLE) ? rx_s : 1'b1;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            if (state_q == ST_IDLE) begin
                s_cnt_q   <= '0;
                bit_idx_q <= '0;
            end else if (tick) begin
                s_cnt_q <= s_cnt_q + 1'b1;
            end
            if (tick && s_cnt_q == SMP_A) smp_a_q <= rx_s;
            if (tick && s_cnt_q == SMP_B) smp_b_q <= rx_s;
            if (state_q == ST_DATA && at_mid) shift_q <= {maj, shift_q[7:1]};
            if (state_q == ST_DATA && at_end) bit_idx_q <= bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (state_q == ST_PARITY && at_mid) par_q <= maj;
`endif
            if (valid_d) data_q <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - directed self-checking bench for uart_rx_os16 (macro UART_RX_PARITY_EN)
module tb_uart_rx_os16;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int DIV      = 10;
    localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // 2 synchronizer clocks + 1 edge-detect clock, then the stop bit's
    // tick 9 is the ((FRAME_BITS-1)*16+10)th tick, strobe registered on it.
    localparam int VALID_OFS = 3 + ((FRAME_BITS - 1) * 16 + 10) * DIV;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_rx  = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_parity_err, o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc    = 0;
    int vcnt   = 0;
    int fcnt   = 0;
    int pcnt   = 0;
    int pv_cnt = 0;
    int v_cyc  = 0;
    logic [7:0] vdata[$];

    uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) begin
            vcnt  <= vcnt + 1;
            v_cyc <= cyc;
            vdata.push_back(o_data);
            if (o_parity_err) pv_cnt <= pv_cnt + 1;
        end
        if (o_frame_err)  fcnt <= fcnt + 1;
        if (o_parity_err) pcnt <= pcnt + 1;
    end

    task automatic send_bit(input logic b);
        i_rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) i_rx = 1'b0;
`endif
        send_bit(stop);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        i_rx  = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (o_data !== 8'h00) begin
            $display("FAIL reset_data: got %h expected 00", o_data); n_fail++;
        end
        n_checks++;
        if ({o_valid, o_frame_err, o_parity_err, o_busy} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000",
                     {o_valid, o_frame_err, o_parity_err, o_busy}); n_fail++;
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if ({vcnt, fcnt, pcnt} !== {32'd0, 32'd0, 32'd0} || o_busy !== 1'b0) begin
            $display("FAIL reset_quiet: valid=%0d ferr=%0d perr=%0d busy=%b expected 0 0 0 0",
                     vcnt, fcnt, pcnt, o_busy); n_fail++;
        end
    endtask

    task automatic test_single_byte;
        int v0, f0, p0, c0;
        v0 = vcnt; f0 = fcnt; p0 = pcnt;
        c0 = cyc;
        send_byte(8'h41);
        i_rx = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (vcnt - v0 !== 1) begin
            $display("FAIL single_count: got %0d expected 1", vcnt - v0); n_fail++;
        end
        n_checks++;
        if (o_data !== 8'h41) begin
            $display("FAIL single_data: got %h expected 41", o_data); n_fail++;
        end
        n_checks++;
        if (v_cyc - c0 !== VALID_OFS) begin
            $display("FAIL single_latency: got %0d expected %0d", v_cyc - c0, VALID_OFS); n_fail++;
        end
        n_checks++;
        if (fcnt - f0 !== 0 || pcnt - p0 !== 0) begin
            $display("FAIL single_no_err: ferr=%0d perr=%0d expected 0 0", fcnt - f0, pcnt - p0);
            n_fail++;
        end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        i_rx = 1'b0;
        repeat (30) @(negedge clk);
        i_rx = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b1) begin
            $display("FAIL glitch_busy_high: got %b expected 1", o_busy); n_fail++;
        end
        repeat (200) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin
            $display("FAIL glitch_busy_low: got %b expected 0", o_busy); n_fail++;
        end
        n_checks++;
        if (vcnt !== v0 || fcnt !== f0) begin
            $display("FAIL glitch_no_strobe: valid=%0d ferr=%0d expected 0 0", vcnt - v0, fcnt - f0);
            n_fail++;
        end
    endtask

    task automatic test_frame_error;
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_checks++;
        if (fcnt - f0 !== 1) begin
            $display("FAIL ferr_count: got %0d expected 1", fcnt - f0); n_fail++;
        end
        n_checks++;
        if (vcnt !== v0) begin
            $display("FAIL ferr_no_valid: got %0d expected 0", vcnt - v0); n_fail++;
        end
        n_checks++;
        if (o_data !== 8'h41) begin
            $display("FAIL ferr_data_held: got %h expected 41", o_data); n_fail++;
        end
        n_checks++;
        if (o_busy !== 1'b1) begin
            $display("FAIL ferr_busy_break: got %b expected 1", o_busy); n_fail++;
        end
        i_rx = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin
            $display("FAIL ferr_busy_release: got %b expected 0", o_busy); n_fail++;
        end
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[3];
        int v0, f0, qi;
        exp_q[0] = 8'h00; exp_q[1] = 8'hFF; exp_q[2] = 8'hA5;
        v0 = vcnt; f0 = fcnt; qi = vdata.size();
        for (int i = 0; i < 3; i++) send_byte(exp_q[i]);
        i_rx = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (vcnt - v0 !== 3) begin
            $display("FAIL b2b_count: got %0d expected 3", vcnt - v0); n_fail++;
        end
        n_checks++;
        if (fcnt !== f0) begin
            $display("FAIL b2b_no_ferr: got %0d expected 0", fcnt - f0); n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (vdata.size() <= qi + i) begin
                $display("FAIL b2b_data%0d: got none expected %h", i, exp_q[i]); n_fail++;
            end else if (vdata[qi+i] !== exp_q[i]) begin
                $display("FAIL b2b_data%0d: got %h expected %h", i, vdata[qi+i], exp_q[i]); n_fail++;
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] first = 8'h3C;
        int v0, f0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(first[i]);
        i_rx = first[4];
        repeat (80) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b1) begin
            $display("FAIL mid_busy_before: got %b expected 1", o_busy); n_fail++;
        end
        rst_n = 1'b0;
        i_rx  = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_data !== 8'h00) begin
            $display("FAIL mid_reset_data: got %h expected 00", o_data); n_fail++;
        end
        n_checks++;
        if ({o_valid, o_frame_err, o_parity_err, o_busy} !== 4'b0000) begin
            $display("FAIL mid_reset_flags: got %b expected 0000",
                     {o_valid, o_frame_err, o_parity_err, o_busy}); n_fail++;
        end
        repeat (5) @(negedge clk);
        v0 = vcnt; f0 = fcnt;
        rst_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        n_checks++;
        if (vcnt !== v0 || fcnt !== f0 || o_busy !== 1'b0) begin
            $display("FAIL mid_post_quiet: valid=%0d ferr=%0d busy=%b expected 0 0 0",
                     vcnt - v0, fcnt - f0, o_busy); n_fail++;
        end
        send_byte(8'h7E);
        i_rx = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (vcnt - v0 !== 1) begin
            $display("FAIL mid_count: got %0d expected 1", vcnt - v0); n_fail++;
        end
        n_checks++;
        if (o_data !== 8'h7E) begin
            $display("FAIL mid_data: got %h expected 7E", o_data); n_fail++;
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int v0, p0, pv0;
        v0 = vcnt; p0 = pcnt; pv0 = pv_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        i_rx = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (vcnt - v0 !== 1 || pcnt - p0 !== 1 || pv_cnt - pv0 !== 1) begin
            $display("FAIL parity_bad: valid=%0d perr=%0d both=%0d expected 1 1 1",
                     vcnt - v0, pcnt - p0, pv_cnt - pv0); n_fail++;
        end
        n_checks++;
        if (o_data !== 8'h07) begin
            $display("FAIL parity_bad_data: got %h expected 07", o_data); n_fail++;
        end
        v0 = vcnt; p0 = pcnt;
        send_frame(8'h07, 1'b1, 1'b1);
        i_rx = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (vcnt - v0 !== 1 || pcnt !== p0) begin
            $display("FAIL parity_good: valid=%0d perr=%0d expected 1 0", vcnt - v0, pcnt - p0);
            n_fail++;
        end
    endtask
`else
    task automatic test_parity;
        n_checks++;
        if (pcnt !== 0 || o_parity_err !== 1'b0) begin
            $display("FAIL parity_tied: strobes=%0d level=%b expected 0 0", pcnt, o_parity_err);
            n_fail++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os16.md
UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
- REQ-001 The module SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
- REQ-002 The module SHALL have parameter BAUD, default 9600, meaning line bit rate.
- REQ-003 The module SHALL have port clk, input, 1 bit: the system clock, rising-edge.
- REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-005 The module SHALL have port i_rx, input, 1 bit: serial line, idle high, asynchronous to clk.
- REQ-006 The module SHALL have port o_data, output, 8 bits: last received byte.
- REQ-007 The module SHALL have port o_valid, output, 1 bit: single-cycle strobe, o_data is new.
- REQ-008 The module SHALL have port o_frame_err, output, 1 bit: single-cycle strobe, stop bit sampled low.
- REQ-009 The module SHALL have port o_parity_err, output, 1 bit: single-cycle strobe, parity mismatch; tied 0 without the macro.
- REQ-010 The module SHALL have port o_busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
- REQ-011 i_rx SHALL pass through a 2-flop synchronizer, both flops resetting to 1; all logic uses the synchronized value.
- REQ-012 The sample tick SHALL pulse every DIV = max(1, CLK_FREQ/(BAUD*16)) clocks (integer floor), counter restarted on entry to START.
- REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- REQ-014 IDLE->START SHALL occur on a synchronized high-to-low transition; the tick counter and the 4-bit sample counter clear.
- REQ-015 Each bit SHALL occupy 16 ticks; bit value = majority of samples at ticks 7, 8, 9.
- REQ-016 START majority 1 SHALL return to IDLE with no strobe (glitch rejection).
- REQ-017 DATA SHALL shift 8 bits LSB first, a 3-bit index counting 0..7, then advance to PARITY or STOP.
- REQ-018 STOP majority 1 SHALL, on the clock after the tick-9 sample, load o_data and pulse o_valid, then go to IDLE (no wait for the remaining ticks).
- REQ-019 STOP majority 0 SHALL pulse o_frame_err, leave o_data unchanged, no o_valid, and go to BREAK.
- REQ-020 BREAK SHALL remain until the synchronized line reads 1, then go to IDLE.
- REQ-021 o_data SHALL hold its value between o_valid strobes.
- REQ-022 Strobes SHALL be mutually exclusive per frame, except that o_parity_err and o_valid both pulse when parity fails with a good stop bit.
- REQ-023 A falling edge seen in the same clock as the return to IDLE SHALL be detected on the next clock; back-to-back frames with a 1-bit stop SHALL all be received.

Reset
- REQ-024 Asserting rst_n low SHALL force IDLE, o_data=0x00, o_valid, o_frame_err, o_parity_err and o_busy low, all counters 0, synchronizer flops 1, including mid-frame.
- REQ-025 After release, no strobe SHALL occur until a complete new frame is received.

Configuration
- REQ-026 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL sample a 9th bit, even parity (XOR of data plus parity bit = 0 is good), pulsing o_parity_err on mismatch.
- REQ-027 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, the PARITY state and its logic absent, and o_parity_err constant 0.

Structure
- REQ-028 Package uart_pkg SHALL hold the FSM state type, OVERSAMPLE=16, the sample positions 7/8/9, and a 3-input majority function.
- REQ-029 Sub-module uart_baud_tick SHALL contain the DIV counter with a restart input and tick output; the FSM stays in uart_rx_os16.

Verification (CLK_FREQ=1600000, BAUD=10000, DIV=10)
- REQ-030 Send 0x41 8N1 -> exactly one o_valid, o_data=0x41, strobe 1 clock after the stop-bit tick-9 sample.
- REQ-031 i_rx low for 30 clocks only -> return to IDLE, no strobes, o_busy drops.
- REQ-032 0x55 with stop bit 0, line held low 3 bit-times -> one o_frame_err, o_data unchanged, o_busy high until line high.
- REQ-033 0x00, 0xFF, 0xA5 back-to-back, 1 stop bit -> three o_valid strobes in order with matching data.
- REQ-034 rst_n pulsed low during bit 4 of 0x3C, then 0x7E sent -> outputs 0 during reset, single o_valid with 0x7E.
- REQ-035 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> o_parity_err and o_valid both pulse, o_data=0x07; 0x07 with parity bit 1 -> o_valid only.
